// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response of EX-issued
// loads/stores, aligns/extends load data and forms the MEM->WB bus.
module mem_stage #(
  parameter int ES_BUS_W = 142,
  parameter int MS_BUS_W = 136,
  parameter int CANCEL_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                es_to_ms_valid,
  output logic                ms_allowin,
  input  logic [ES_BUS_W-1:0] es_to_ms_bus,
  input  logic                ws_allowin,
  output logic                ms_to_ws_valid,
  output logic [MS_BUS_W-1:0] ms_to_ws_bus,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                ws_reflush_ms,
  output logic [4:0]          ms_to_ds_dest,
  output logic [31:0]         ms_to_ds_value,
  output logic                ms_load_block,
  output logic                ms_csr,
  output logic                ms_ex_or_ertn,
  output logic [CANCEL_W-1:0] dbg_cancel_cnt,
  output logic                dbg_data_buf_valid,
  output logic                dbg_ms_valid
);

  localparam logic [CANCEL_W-1:0] CNT_MAX = '1;

  logic                ms_valid_q, ms_valid_d;
  logic [ES_BUS_W-1:0] es_bus_q, es_bus_d;
  logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;
  logic                data_buf_valid_q, data_buf_valid_d;
  logic [31:0]         data_buf_q, data_buf_d;

  // Field view of the latched EX bus
  logic                mem_req;
  logic [4:0]          load_op;
  logic [MS_BUS_W-1:0] ms_bus;
  logic                ertn, csr_we, csr_rd, gr_we;
  logic [16:0]         ex_cause;
  logic [4:0]          dest;
  logic [31:0]         in_result;

  assign mem_req   = es_bus_q[141];
  assign load_op   = es_bus_q[140:136];
  assign ms_bus    = es_bus_q[135:0];
  assign ertn      = ms_bus[135];
  assign csr_we    = ms_bus[134];
  assign csr_rd    = ms_bus[133];
  assign ex_cause  = ms_bus[86:70];
  assign gr_we     = ms_bus[69];
  assign dest      = ms_bus[68:64];
  assign in_result = ms_bus[63:32];

  logic need_resp, cnt_zero, resp_accept, ms_ready_go, leave;
  logic cnt_inc, cnt_dec, is_load;

  assign is_load     = load_op != 5'b0;
  assign need_resp   = ms_valid_q & mem_req & (ex_cause == 17'b0);
  assign cnt_zero    = cancel_cnt_q == '0;
  assign resp_accept = data_sram_data_ok & cnt_zero;
  assign ms_ready_go = !need_resp | data_buf_valid_q | resp_accept;

  assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go & !ws_reflush_ms;
  assign leave          = ms_to_ws_valid & ws_allowin;

  // A flushed instruction whose response is still owed leaves one stale data_ok behind
  assign cnt_dec = data_sram_data_ok & !cnt_zero;
  assign cnt_inc = ws_reflush_ms & need_resp & !data_buf_valid_q & !resp_accept;

  // Load alignment and extension
  logic [31:0] rd_word;
  logic [1:0]  addr_lo;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] final_result;

  assign rd_word = data_buf_valid_q ? data_buf_q : data_sram_rdata;
  assign addr_lo = in_result[1:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (addr_lo)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
    rd_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_val = rd_word;
    if (load_op[4])      load_val = {{24{rd_byte[7]}}, rd_byte};
    else if (load_op[3]) load_val = {{16{rd_half[15]}}, rd_half};
    else if (load_op[2]) load_val = rd_word;
    else if (load_op[1]) load_val = {24'b0, rd_byte};
    else if (load_op[0]) load_val = {16'b0, rd_half};
  end

  assign final_result = is_load ? load_val : in_result;
  assign ms_to_ws_bus = {ms_bus[135:64], final_result, ms_bus[31:0]};

  assign ms_to_ds_dest  = (ms_valid_q & gr_we) ? dest : 5'b0;
  assign ms_to_ds_value = (ms_valid_q & gr_we) ? final_result : 32'b0;
  assign ms_load_block  = ms_valid_q & is_load & !ms_ready_go;
  assign ms_csr         = ms_valid_q & (csr_we | csr_rd);
  assign ms_ex_or_ertn  = ms_valid_q & ((ex_cause != 17'b0) | ertn);

  assign dbg_cancel_cnt     = cancel_cnt_q;
  assign dbg_data_buf_valid = data_buf_valid_q;
  assign dbg_ms_valid       = ms_valid_q;

  always_comb begin
    ms_valid_d       = ms_valid_q;
    es_bus_d         = es_bus_q;
    data_buf_valid_d = data_buf_valid_q;
    data_buf_d       = data_buf_q;
    cancel_cnt_d     = cancel_cnt_q;

    if (ws_reflush_ms) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
      if (es_to_ms_valid) es_bus_d = es_to_ms_bus;
    end

    // Hold an accepted response while write-back stalls us
    if (ws_reflush_ms || leave) begin
      data_buf_valid_d = 1'b0;
    end else if (resp_accept && need_resp && !ws_allowin && !data_buf_valid_q) begin
      data_buf_valid_d = 1'b1;
      data_buf_d       = data_sram_rdata;
    end

    case ({cnt_inc, cnt_dec})
      2'b10:   cancel_cnt_d = (cancel_cnt_q == CNT_MAX) ? cancel_cnt_q
                                                        : cancel_cnt_q + CANCEL_W'(1);
      2'b01:   cancel_cnt_d = cancel_cnt_q - CANCEL_W'(1);
      default: cancel_cnt_d = cancel_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ms_valid_q       <= 1'b0;
      es_bus_q         <= '0;
      cancel_cnt_q     <= '0;
      data_buf_valid_q <= 1'b0;
      data_buf_q       <= 32'b0;
    end else begin
      ms_valid_q       <= ms_valid_d;
      es_bus_q         <= es_bus_d;
      cancel_cnt_q     <= cancel_cnt_d;
      data_buf_valid_q <= data_buf_valid_d;
      data_buf_q       <= data_buf_d;
    end
  end

  // More outstanding stale responses than the counter can track is a system error
  always_ff @(posedge clk) begin
    if (reset && cnt_inc && !cnt_dec) begin
      assert (cancel_cnt_q != CNT_MAX);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of load/store vectors plus hand-written
// buffer, flush, exception and reset sequences, checked through an expected queue.
module tb_mem_stage;

  // Handshake: an instruction moves MEM->WB in a cycle where
  // ms_to_ws_valid && ws_allowin at the rising edge; EX->MEM likewise with
  // es_to_ms_valid && ms_allowin.

  localparam logic [4:0] LD_B  = 5'b10000;
  localparam logic [4:0] LD_H  = 5'b01000;
  localparam logic [4:0] LD_W  = 5'b00100;
  localparam logic [4:0] LD_BU = 5'b00010;
  localparam logic [4:0] LD_HU = 5'b00001;
  localparam int NV = 12;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          es_to_ms_valid;
  logic          ms_allowin;
  logic [141:0]  es_to_ms_bus;
  logic          ws_allowin;
  logic          ms_to_ws_valid;
  logic [135:0]  ms_to_ws_bus;
  logic          data_sram_data_ok;
  logic [31:0]   data_sram_rdata;
  logic          ws_reflush_ms;
  logic [4:0]    ms_to_ds_dest;
  logic [31:0]   ms_to_ds_value;
  logic          ms_load_block;
  logic          ms_csr;
  logic          ms_ex_or_ertn;
  logic [1:0]    dbg_cancel_cnt;
  logic          dbg_data_buf_valid;
  logic          dbg_ms_valid;

  mem_stage dut (
    .clk                (clk),
    .reset              (reset),
    .es_to_ms_valid     (es_to_ms_valid),
    .ms_allowin         (ms_allowin),
    .es_to_ms_bus       (es_to_ms_bus),
    .ws_allowin         (ws_allowin),
    .ms_to_ws_valid     (ms_to_ws_valid),
    .ms_to_ws_bus       (ms_to_ws_bus),
    .data_sram_data_ok  (data_sram_data_ok),
    .data_sram_rdata    (data_sram_rdata),
    .ws_reflush_ms      (ws_reflush_ms),
    .ms_to_ds_dest      (ms_to_ds_dest),
    .ms_to_ds_value     (ms_to_ds_value),
    .ms_load_block      (ms_load_block),
    .ms_csr             (ms_csr),
    .ms_ex_or_ertn      (ms_ex_or_ertn),
    .dbg_cancel_cnt     (dbg_cancel_cnt),
    .dbg_data_buf_valid (dbg_data_buf_valid),
    .dbg_ms_valid       (dbg_ms_valid)
  );

  // scoreboard
  logic [135:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_bit(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_bus(input string name, input logic [135:0] act, input logic [135:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic monitor();
    logic [135:0] e;
    if (ms_to_ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h, required no transfer", ms_to_ws_bus);
      end else begin
        e = exp_q.pop_front();
        chk_bus("wb_bus", ms_to_ws_bus, e);
        chk_word("ds_value", ms_to_ds_value, e[69] ? e[63:32] : 32'h0);
        chk_word("ds_dest", {27'b0, ms_to_ds_dest}, e[69] ? {27'b0, e[68:64]} : 32'h0);
      end
    end
  endtask

  // sample away from the active edge, then advance to just after the next one
  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [135:0] make_bus(
    input logic ertn, input logic csr_we, input logic csr_rd,
    input logic [31:0] wmask, input logic [13:0] num, input logic [16:0] exc,
    input logic gr_we, input logic [4:0] dest, input logic [31:0] fr,
    input logic [31:0] pc);
    return {ertn, csr_we, csr_rd, wmask, num, exc, gr_we, dest, fr, pc};
  endfunction

  typedef struct {
    logic [4:0]  op;
    logic        mem_req;
    logic [31:0] fr;
    logic [31:0] rdata;
    logic [31:0] res;
    int          delay;
  } vec_t;

  vec_t vec[NV];
  logic [135:0] in_bus, exp_bus;
  logic [31:0]  r1, r2, r3;

  initial begin
    vec[0]  = '{LD_W,  1'b1, 32'h0000_1000, 32'h1122_3344, 32'h1122_3344, 2};
    vec[1]  = '{LD_B,  1'b1, 32'h0000_1003, 32'h80FF_FFFF, 32'hFFFF_FF80, 0};
    vec[2]  = '{LD_BU, 1'b1, 32'h0000_1003, 32'h80FF_FFFF, 32'h0000_0080, 0};
    vec[3]  = '{LD_HU, 1'b1, 32'h0000_1002, 32'hBEEF_0000, 32'h0000_BEEF, 0};
    vec[4]  = '{LD_H,  1'b1, 32'h0000_1002, 32'hBEEF_0000, 32'hFFFF_BEEF, 0};
    vec[5]  = '{LD_H,  1'b1, 32'h0000_2000, 32'h1234_7FFE, 32'h0000_7FFE, 0};
    vec[6]  = '{LD_B,  1'b1, 32'h0000_2000, 32'h1234_56F0, 32'hFFFF_FFF0, 0};
    vec[7]  = '{LD_B,  1'b1, 32'h0000_2001, 32'h1234_7F00, 32'h0000_007F, 0};
    vec[8]  = '{LD_BU, 1'b1, 32'h0000_2002, 32'h12AB_5678, 32'h0000_00AB, 0};
    vec[9]  = '{LD_HU, 1'b1, 32'h0000_2000, 32'h0000_F00D, 32'h0000_F00D, 0};
    vec[10] = '{5'b0,  1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 0};
    vec[11] = '{5'b0,  1'b1, 32'h0000_3000, 32'hFFFF_FFFF, 32'h0000_3000, 0};
    for (int i = 1; i < NV; i++) vec[i].delay = $urandom_range(0, 3);

    reset = 1'b0;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    ws_reflush_ms = 1'b0;

    // reset state
    adv();
    adv();
    sample();
    chk_bit("rst_allowin", ms_allowin, 1'b1);
    chk_bit("rst_out_valid", ms_to_ws_valid, 1'b0);
    chk_bit("rst_ms_valid", dbg_ms_valid, 1'b0);
    chk_word("rst_cancel_cnt", {30'b0, dbg_cancel_cnt}, 32'h0);
    chk_bit("rst_load_block", ms_load_block, 1'b0);
    chk_word("rst_ds_dest", {27'b0, ms_to_ds_dest}, 32'h0);
    adv();
    reset = 1'b1;

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      r1 = $urandom();
      r2 = $urandom();
      r3 = $urandom();
      in_bus  = make_bus(1'b0, r1[0], r1[1], r2, r3[13:0], 17'h0, r1[2], r1[7:3],
                         vec[i].fr, {r3[31:2], 2'b00});
      exp_bus = make_bus(1'b0, r1[0], r1[1], r2, r3[13:0], 17'h0, r1[2], r1[7:3],
                         vec[i].res, {r3[31:2], 2'b00});
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = {vec[i].mem_req, vec[i].op, in_bus};
      exp_q.push_back(exp_bus);
      sample();
      chk_bit("vec_allowin_idle", ms_allowin, 1'b1);
      adv();
      es_to_ms_valid = 1'b0;
      if (vec[i].mem_req) begin
        for (int d = 0; d < vec[i].delay; d++) begin
          sample();
          chk_bit("vec_load_block", ms_load_block, vec[i].op != 5'b0);
          chk_bit("vec_wait_no_out", ms_to_ws_valid, 1'b0);
          chk_bit("vec_wait_allowin", ms_allowin, 1'b0);
          adv();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = vec[i].rdata;
      end
      sample();
      chk_bit("vec_out_valid", ms_to_ws_valid, 1'b1);
      chk_bit("vec_csr", ms_csr, r1[0] | r1[1]);
      chk_bit("vec_ex_or_ertn", ms_ex_or_ertn, 1'b0);
      adv();
      data_sram_data_ok = 1'b0;
      data_sram_rdata = $urandom();
    end

    // write-back stall when data_ok arrives: response is buffered
    in_bus = make_bus(1'b0, 1'b0, 1'b0, 32'h0, 14'h0, 17'h0, 1'b1, 5'd7,
                      32'h0000_4000, 32'h1C00_0100);
    exp_bus = make_bus(1'b0, 1'b0, 1'b0, 32'h0, 14'h0, 17'h0, 1'b1, 5'd7,
                       32'hA5A5_A5A5, 32'h1C00_0100);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = {1'b1, LD_W, in_bus};
    exp_q.push_back(exp_bus);
    sample();
    adv();
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hA5A5_A5A5;
    sample();
    chk_bit("buf_out_valid", ms_to_ws_valid, 1'b1);
    chk_bit("buf_allowin0", ms_allowin, 1'b0);
    adv();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    sample();
    chk_bit("buf_valid_set", dbg_data_buf_valid, 1'b1);
    chk_bit("buf_allowin1", ms_allowin, 1'b0);
    chk_bit("buf_held_valid", ms_to_ws_valid, 1'b1);
    chk_bit("buf_no_block", ms_load_block, 1'b0);
    adv();
    ws_allowin = 1'b1;
    sample();
    chk_bit("buf_release_allowin", ms_allowin, 1'b1);
    adv();
    sample();
    chk_bit("buf_valid_clr", dbg_data_buf_valid, 1'b0);
    chk_bit("buf_gone", ms_to_ws_valid, 1'b0);
    adv();

    // flush while a load waits; its stale response must be dropped
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = {1'b1, LD_W, make_bus(1'b0, 1'b0, 1'b0, 32'h0, 14'h0, 17'h0, 1'b1,
                                         5'd3, 32'h0000_5000, 32'h1C00_0200)};
    sample();
    adv();
    es_to_ms_valid = 1'b0;
    sample();
    chk_bit("fl_wait_block", ms_load_block, 1'b1);
    adv();
    ws_reflush_ms = 1'b1;
    sample();
    chk_bit("fl_no_out", ms_to_ws_valid, 1'b0);
    adv();
    ws_reflush_ms = 1'b0;
    in_bus = make_bus(1'b0, 1'b0, 1'b0, 32'h0, 14'h0, 17'h0, 1'b1, 5'd9,
                      32'h0000_6000, 32'h1C00_0300);
    exp_bus = make_bus(1'b0, 1'b0, 1'b0, 32'h0, 14'h0, 17'h0, 1'b1, 5'd9,
                       32'h0000_0005, 32'h1C00_0300);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = {1'b1, LD_W, in_bus};
    exp_q.push_back(exp_bus);
    sample();
    chk_word("fl_cnt_one", {30'b0, dbg_cancel_cnt}, 32'h1);
    chk_bit("fl_allowin", ms_allowin, 1'b1);
    adv();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0000_0BAD;
    sample();
    chk_bit("fl_stale_no_out", ms_to_ws_valid, 1'b0);
    chk_bit("fl_stale_block", ms_load_block, 1'b1);
    adv();
    data_sram_rdata = 32'h0000_0005;
    sample();
    chk_word("fl_cnt_zero", {30'b0, dbg_cancel_cnt}, 32'h0);
    chk_bit("fl_next_out", ms_to_ws_valid, 1'b1);
    adv();
    data_sram_data_ok = 1'b0;
    sample();
    chk_bit("fl_single_out", ms_to_ws_valid, 1'b0);
    adv();

    // flush in the same cycle as the waiting load's own data_ok
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = {1'b1, LD_W, make_bus(1'b0, 1'b0, 1'b0, 32'h0, 14'h0, 17'h0, 1'b1,
                                         5'd4, 32'h0000_7000, 32'h1C00_0400)};
    sample();
    adv();
    es_to_ms_valid = 1'b0;
    ws_reflush_ms = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1234_5678;
    sample();
    chk_bit("flok_no_out", ms_to_ws_valid, 1'b0);
    adv();
    ws_reflush_ms = 1'b0;
    data_sram_data_ok = 1'b0;
    sample();
    chk_word("flok_cnt", {30'b0, dbg_cancel_cnt}, 32'h0);
    chk_bit("flok_ms_valid", dbg_ms_valid, 1'b0);
    adv();

    // exception with mem_req: no wait for a response
    in_bus = make_bus(1'b0, 1'b1, 1'b0, 32'h0, 14'h5, 17'h8, 1'b0, 5'd0,
                      32'h0000_8001, 32'h1C00_0500);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = {1'b1, 5'b0, in_bus};
    exp_q.push_back(in_bus);
    sample();
    adv();
    es_to_ms_valid = 1'b0;
    sample();
    chk_bit("exc_out_valid", ms_to_ws_valid, 1'b1);
    chk_bit("exc_ex_or_ertn", ms_ex_or_ertn, 1'b1);
    chk_bit("exc_csr", ms_csr, 1'b1);
    adv();
    sample();
    chk_bit("exc_ex_clear", ms_ex_or_ertn, 1'b0);
    adv();

    // reset mid-wait with one stale response outstanding
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = {1'b1, LD_W, make_bus(1'b0, 1'b0, 1'b0, 32'h0, 14'h0, 17'h0, 1'b1,
                                         5'd5, 32'h0000_9000, 32'h1C00_0600)};
    sample();
    adv();
    es_to_ms_valid = 1'b0;
    ws_reflush_ms = 1'b1;
    sample();
    adv();
    ws_reflush_ms = 1'b0;
    es_to_ms_valid = 1'b1;
    sample();
    adv();
    es_to_ms_valid = 1'b0;
    sample();
    chk_word("rw_cnt_one", {30'b0, dbg_cancel_cnt}, 32'h1);
    chk_bit("rw_block", ms_load_block, 1'b1);
    adv();
    reset = 1'b0;
    sample();
    adv();
    reset = 1'b1;
    sample();
    chk_bit("rw_ms_valid", dbg_ms_valid, 1'b0);
    chk_word("rw_cnt_zero", {30'b0, dbg_cancel_cnt}, 32'h0);
    chk_bit("rw_allowin", ms_allowin, 1'b1);
    chk_bit("rw_no_block", ms_load_block, 1'b0);
    adv();

    chk_word("queue_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
